// File: rtl/ltf_detector.sv
// LTF detector: sign-correlates a 64-sample window against the LTF pattern, locks on two peaks 64 apart, then forwards samples.
// Latency: score/score_stb, ltf_found, ltf_timeout and out_sample/out_stb all appear 1 cycle after the sample_stb that caused them.
// No backpressure: every sample_stb is consumed in the cycle it is presented.
module ltf_detector #(
    parameter int THRESHOLD = 112,
    parameter int GAP_TOL   = 1,
    parameter int TIMEOUT   = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         arm,
    input  logic [127:0] ref_signs,
    input  logic [31:0]  sample_in,
    input  logic         sample_stb,
    output logic [7:0]   score,
    output logic         score_stb,
    output logic         ltf_found,
    output logic         ltf_timeout,
    output logic         locked,
    output logic [6:0]   peak_gap,
    output logic [7:0]   peak_score,
    output logic [31:0]  out_sample,
    output logic         out_stb
);

    localparam int             TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TOUT   = TW'(TIMEOUT);
    localparam logic [7:0]     THR    = 8'(THRESHOLD);
    localparam logic [6:0]     GAP_LO = 7'(64 - GAP_TOL);
    localparam logic [6:0]     GAP_HI = 7'(64 + GAP_TOL);
    localparam logic [6:0]     FULL   = 7'd64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEARCH1 = 2'd1,
        ST_WAIT2   = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [127:0]   window;
    logic [127:0]   win_base;
    logic [127:0]   win_next;
    logic [6:0]     fill;
    logic [6:0]     fill_base;
    logic [6:0]     fill_next;
    logic [6:0]     gap;
    logic [6:0]     gap_inc;
    logic [TW-1:0]  tcnt;
    logic [TW-1:0]  tcnt_inc;
    logic [7:0]     score_next;
    logic           qualify;
    logic           found_nxt;
    logic           timeout_nxt;

    // Count of matching sign bits; one adder chain, fits the single-cycle score latency.
    function automatic logic [7:0] popcount(input logic [127:0] v);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < 128; i++) begin
            c = c + {7'd0, v[i]};
        end
        return c;
    endfunction

    // Window update: arm clears first so a same-cycle sample becomes the first entry; newest sample enters slot 63.
    always_comb begin
        win_base  = arm ? '0 : window;
        fill_base = arm ? '0 : fill;
        win_next  = win_base;
        fill_next = fill_base;
        if (sample_stb) begin
            win_next = {sample_in[31], sample_in[15], win_base[127:2]};
            if (fill_base != FULL) begin
                fill_next = fill_base + 7'd1;
            end
        end
        score_next = popcount(~(win_next ^ ref_signs));
        qualify    = sample_stb && (fill_next == FULL) && (score_next >= THR);
        gap_inc    = gap + 7'd1;
        tcnt_inc   = tcnt + 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; decisions use the score being registered this cycle so pulses line up with score_stb.
    always_comb begin
        state_nxt = state;
        if (arm) begin
            state_nxt = ST_SEARCH1;
        end else if (sample_stb) begin
            case (state)
                ST_SEARCH1: begin
                    if (qualify) begin
                        state_nxt = ST_WAIT2;
                    end else if (tcnt_inc == TOUT) begin
                        state_nxt = ST_IDLE;
                    end
                end
                ST_WAIT2: begin
                    if (qualify && gap_inc >= GAP_LO && gap_inc <= GAP_HI) begin
                        state_nxt = ST_LOCKED;
                    end else if (gap_inc > GAP_HI) begin
                        state_nxt = ST_SEARCH1;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    // FSM pulse outputs, derived from the transition being taken.
    always_comb begin
        found_nxt   = !arm && sample_stb && (state == ST_WAIT2) && (state_nxt == ST_LOCKED);
        timeout_nxt = !arm && sample_stb && (state == ST_SEARCH1) && (state_nxt == ST_IDLE);
    end

    // Search counters and peak capture; arm wipes everything from the previous attempt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap        <= '0;
            tcnt       <= '0;
            peak_gap   <= '0;
            peak_score <= '0;
            locked     <= 1'b0;
        end else if (arm) begin
            gap        <= '0;
            tcnt       <= '0;
            peak_gap   <= '0;
            peak_score <= '0;
            locked     <= 1'b0;
        end else if (sample_stb) begin
            case (state)
                ST_SEARCH1: begin
                    if (qualify) begin
                        gap <= '0;
                    end else begin
                        tcnt <= tcnt_inc;
                    end
                end
                ST_WAIT2: begin
                    gap <= gap_inc;
                    if (found_nxt) begin
                        peak_gap   <= gap_inc;
                        peak_score <= score_next;
                        locked     <= 1'b1;
                    end else if (gap_inc > GAP_HI) begin
                        // Window is kept; the next peak may be found immediately.
                        tcnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Window, score and forwarded-sample pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            window      <= '0;
            fill        <= '0;
            score       <= '0;
            score_stb   <= 1'b0;
            ltf_found   <= 1'b0;
            ltf_timeout <= 1'b0;
            out_sample  <= '0;
            out_stb     <= 1'b0;
        end else begin
            window      <= win_next;
            fill        <= fill_next;
            score_stb   <= sample_stb;
            ltf_found   <= found_nxt;
            ltf_timeout <= timeout_nxt;
            if (sample_stb) begin
                score <= score_next;
            end
            out_stb <= !arm && sample_stb && (state == ST_LOCKED);
            if (!arm && sample_stb && (state == ST_LOCKED)) begin
                out_sample <= sample_in;
            end
        end
    end

endmodule

// File: tb/tb_ltf_detector.sv
// Directed bench for ltf_detector: loopback lock, gap error, spacing tolerance, timeout, re-arm and reset.
// Symbols are built from ref_signs as +/-1000 IQ samples, so an aligned window matches all 128 bits.
module tb_ltf_detector;

    logic         clk = 1'b0;
    logic         reset;
    logic         arm;
    logic [127:0] ref_signs;
    logic [31:0]  sample_in;
    logic         sample_stb;
    logic [7:0]   score;
    logic         score_stb;
    logic         ltf_found;
    logic         ltf_timeout;
    logic         locked;
    logic [6:0]   peak_gap;
    logic [7:0]   peak_score;
    logic [31:0]  out_sample;
    logic         out_stb;

    int checks = 0;
    int failures = 0;
    int idx = 0;
    int found_cnt, found_idx, timeout_cnt, timeout_idx, out_cnt;
    logic [31:0] out_log [0:15];
    logic [7:0]  score_log [0:2047];

    always #5 clk = ~clk;

    ltf_detector dut (
        .clk        (clk),
        .reset      (reset),
        .arm        (arm),
        .ref_signs  (ref_signs),
        .sample_in  (sample_in),
        .sample_stb (sample_stb),
        .score      (score),
        .score_stb  (score_stb),
        .ltf_found  (ltf_found),
        .ltf_timeout(ltf_timeout),
        .locked     (locked),
        .peak_gap   (peak_gap),
        .peak_score (peak_score),
        .out_sample (out_sample),
        .out_stb    (out_stb)
    );

    function automatic logic [31:0] ltf_smp(input int k);
        logic [15:0] i_v;
        logic [15:0] q_v;
        i_v = ref_signs[2*k+1] ? 16'hFC18 : 16'h03E8;
        q_v = ref_signs[2*k]   ? 16'hFC18 : 16'h03E8;
        return {i_v, q_v};
    endfunction

    task automatic clear_log();
        found_cnt = 0; found_idx = -1; timeout_cnt = 0; timeout_idx = -1; out_cnt = 0;
    endtask

    // One clock: drive at negedge, observe 1 ns after the following posedge.
    task automatic cyc(input logic a, input logic s, input logic [31:0] d);
        @(negedge clk);
        arm = a; sample_stb = s; sample_in = d;
        if (a) idx = 0;
        @(posedge clk);
        #1;
        arm = 1'b0; sample_stb = 1'b0;
        if (score_stb && idx < 2048) score_log[idx] = score;
        if (ltf_found) begin found_cnt++; found_idx = idx; end
        if (ltf_timeout) begin timeout_cnt++; timeout_idx = idx; end
        if (out_stb) begin
            if (out_cnt < 16) out_log[out_cnt] = out_sample;
            out_cnt++;
        end
        if (s) idx++;
    endtask

    task automatic send_sym();
        for (int k = 0; k < 64; k++) cyc(1'b0, 1'b1, ltf_smp(k));
    endtask

    task automatic send_zero(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, 32'h0);
    endtask

    // arm together with LTF sample 0, rest of the symbol, then a second symbol.
    task automatic arm_and_lock();
        cyc(1'b1, 1'b1, ltf_smp(0));
        for (int k = 1; k < 64; k++) cyc(1'b0, 1'b1, ltf_smp(k));
        send_sym();
    endtask

    task automatic test_reset();
        reset = 1'b1; arm = 1'b0; sample_stb = 1'b0; sample_in = '0;
        ref_signs = 128'hC3A59E176B2DF0485A3CE19B27D486F1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({score, score_stb, ltf_found, ltf_timeout, locked} !== 12'h0) begin
            failures++; $display("FAIL reset_ctl got=%h exp=0", {score, score_stb, ltf_found, ltf_timeout, locked});
        end
        checks++;
        if ({peak_gap, peak_score, out_sample, out_stb} !== 48'h0) begin
            failures++; $display("FAIL reset_data got=%h exp=0", {peak_gap, peak_score, out_sample, out_stb});
        end
        @(negedge clk); reset = 1'b0;
        cyc(1'b0, 1'b0, 32'h0);
        checks++;
        if ({locked, ltf_found, ltf_timeout, out_stb, score_stb} !== 5'b0) begin
            failures++; $display("FAIL reset_release got=%b exp=00000", {locked, ltf_found, ltf_timeout, out_stb, score_stb});
        end
    endtask

    task automatic test_loopback();
        clear_log();
        cyc(1'b1, 1'b0, 32'h0);
        for (int n = 0; n < 160; n++) cyc(1'b0, 1'b1, ltf_smp((n + 32) % 64));
        checks++;
        if (score_log[95] !== 8'd128) begin
            failures++; $display("FAIL loop_peak1_score got=%0d exp=128", score_log[95]);
        end
        checks++;
        if (found_cnt !== 1 || found_idx !== 159) begin
            failures++; $display("FAIL loop_found got=%0d@%0d exp=1@159", found_cnt, found_idx);
        end
        checks++;
        if (peak_gap !== 7'd64) begin
            failures++; $display("FAIL loop_gap got=%0d exp=64", peak_gap);
        end
        checks++;
        if (peak_score !== 8'd128) begin
            failures++; $display("FAIL loop_pscore got=%0d exp=128", peak_score);
        end
        checks++;
        if (locked !== 1'b1 || out_cnt !== 0) begin
            failures++; $display("FAIL loop_locked got=%b/%0d exp=1/0", locked, out_cnt);
        end
        for (int n = 0; n < 8; n++) cyc(1'b0, 1'b1, 32'h00010002);
        checks++;
        if (out_cnt !== 8) begin
            failures++; $display("FAIL loop_out_cnt got=%0d exp=8", out_cnt);
        end
        for (int n = 0; n < 8; n++) begin
            checks++;
            if (out_log[n] !== 32'h00010002) begin
                failures++; $display("FAIL loop_out_dat[%0d] got=%h exp=00010002", n, out_log[n]);
            end
        end
        cyc(1'b0, 1'b0, 32'h0);
        checks++;
        if (out_stb !== 1'b0 || score_stb !== 1'b0) begin
            failures++; $display("FAIL loop_idle_stb got=%b%b exp=00", out_stb, score_stb);
        end
    endtask

    task automatic test_gap_error();
        clear_log();
        cyc(1'b1, 1'b0, 32'h0);
        send_sym();
        send_zero(10);
        send_sym();
        send_zero(1100);
        checks++;
        if (found_cnt !== 0 || locked !== 1'b0) begin
            failures++; $display("FAIL gap_err_found got=%0d/%b exp=0/0", found_cnt, locked);
        end
        checks++;
        if (score_log[137] !== 8'd128) begin
            failures++; $display("FAIL gap_err_retake got=%0d exp=128", score_log[137]);
        end
        checks++;
        if (timeout_cnt !== 1 || timeout_idx !== 1227) begin
            failures++; $display("FAIL gap_err_timeout got=%0d@%0d exp=1@1227", timeout_cnt, timeout_idx);
        end
    endtask

    task automatic test_tolerance();
        // spacing 63: second symbol missing its first sample
        clear_log();
        cyc(1'b1, 1'b0, 32'h0);
        send_sym();
        for (int k = 1; k < 64; k++) cyc(1'b0, 1'b1, ltf_smp(k));
        checks++;
        if (found_cnt !== 1 || found_idx !== 126 || peak_gap !== 7'd63) begin
            failures++; $display("FAIL tol63 got=%0d@%0d gap=%0d exp=1@126 gap=63", found_cnt, found_idx, peak_gap);
        end
        checks++;
        if (peak_score !== 8'd127) begin
            failures++; $display("FAIL tol63_pscore got=%0d exp=127", peak_score);
        end
        // spacing 65: one zero between symbols
        clear_log();
        cyc(1'b1, 1'b0, 32'h0);
        send_sym();
        send_zero(1);
        send_sym();
        checks++;
        if (found_cnt !== 1 || found_idx !== 128 || peak_gap !== 7'd65 || peak_score !== 8'd128) begin
            failures++; $display("FAIL tol65 got=%0d@%0d gap=%0d ps=%0d exp=1@128 gap=65 ps=128", found_cnt, found_idx, peak_gap, peak_score);
        end
        // spacing 66: out of tolerance
        clear_log();
        cyc(1'b1, 1'b0, 32'h0);
        send_sym();
        send_zero(2);
        send_sym();
        send_zero(10);
        checks++;
        if (found_cnt !== 0 || locked !== 1'b0) begin
            failures++; $display("FAIL tol66 got=%0d/%b exp=0/0", found_cnt, locked);
        end
    endtask

    task automatic test_timeout();
        clear_log();
        cyc(1'b1, 1'b0, 32'h0);
        send_zero(1024);
        checks++;
        if (timeout_cnt !== 1 || timeout_idx !== 1023) begin
            failures++; $display("FAIL timeout got=%0d@%0d exp=1@1023", timeout_cnt, timeout_idx);
        end
        send_sym();
        send_sym();
        send_zero(8);
        checks++;
        if (found_cnt !== 0 || locked !== 1'b0 || timeout_cnt !== 1 || out_cnt !== 0) begin
            failures++; $display("FAIL timeout_idle got=%0d/%b/%0d/%0d exp=0/0/1/0", found_cnt, locked, timeout_cnt, out_cnt);
        end
    endtask

    task automatic test_rearm_reset();
        // re-arm after peak 1: the following symbol must not pair with the old peak
        clear_log();
        cyc(1'b1, 1'b0, 32'h0);
        send_sym();
        cyc(1'b1, 1'b0, 32'h0);
        send_sym();
        send_zero(20);
        checks++;
        if (found_cnt !== 0 || locked !== 1'b0) begin
            failures++; $display("FAIL rearm_wait2 got=%0d/%b exp=0/0", found_cnt, locked);
        end
        // arm with a sample in the same cycle counts as fill 1
        clear_log();
        arm_and_lock();
        checks++;
        if (found_cnt !== 1 || found_idx !== 127 || peak_gap !== 7'd64) begin
            failures++; $display("FAIL arm_fill1 got=%0d@%0d gap=%0d exp=1@127 gap=64", found_cnt, found_idx, peak_gap);
        end
        // arm while locked clears lock and peak info
        cyc(1'b1, 1'b0, 32'h0);
        checks++;
        if (locked !== 1'b0 || peak_gap !== 7'd0 || peak_score !== 8'd0) begin
            failures++; $display("FAIL arm_clear got=%b/%0d/%0d exp=0/0/0", locked, peak_gap, peak_score);
        end
        // reset while locked with a sample in flight
        arm_and_lock();
        @(negedge clk);
        sample_stb = 1'b1; sample_in = 32'h12345678;
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (locked !== 1'b0 || out_stb !== 1'b0 || peak_gap !== 7'd0) begin
            failures++; $display("FAIL reset_locked got=%b/%b/%0d exp=0/0/0", locked, out_stb, peak_gap);
        end
        @(negedge clk);
        sample_stb = 1'b0; reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_gap_error();
        test_tolerance();
        test_timeout();
        test_rearm_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
